// File: rtl/conv_layer_input_sequencer.sv
// Command sequencer for the conv-layer input interface: one PRELOAD, then per row a
// run of SHIFTs with a LOAD between rows, each command answered by a matching ack.
module conv_layer_input_sequencer #(
  parameter int ROWS           = 6,
  parameter int SHIFTS_PER_ROW = 2,
  parameter int TIMEOUT        = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [1:0]           ack_i,
  output logic [1:0]           cmd_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] row_idx_o,
  output logic [CNT_WIDTH-1:0] shift_idx_o,
  output logic [3:0]           state_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE_REQ  = 4'd1;
  localparam logic [3:0] S_PRE_WAIT = 4'd2;
  localparam logic [3:0] S_SH_REQ   = 4'd3;
  localparam logic [3:0] S_SH_WAIT  = 4'd4;
  localparam logic [3:0] S_LD_REQ   = 4'd5;
  localparam logic [3:0] S_LD_WAIT  = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  localparam logic [CNT_WIDTH-1:0] LAST_ROW   = CNT_WIDTH'(ROWS - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_SHIFT = CNT_WIDTH'(SHIFTS_PER_ROW - 1);
  localparam logic [WD_W-1:0]      WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]      WD_MAX     = WD_W'(TIMEOUT);

  logic [3:0]           state_q, state_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;
  logic [CNT_WIDTH-1:0] shift_q, shift_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [1:0]           exp_ack;

  always_comb begin
    exp_ack = 2'd0;
    case (state_q)
      S_PRE_WAIT: exp_ack = 2'd1;
      S_SH_WAIT:  exp_ack = 2'd2;
      S_LD_WAIT:  exp_ack = 2'd3;
      default:    exp_ack = 2'd0;
    endcase
  end

  // Abort overrides everything; otherwise a low enable freezes all state.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    shift_d = shift_q;
    wd_d    = wd_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else if (enable_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_PRE_REQ;
            row_d   = '0;
            shift_d = '0;
          end
        end
        S_PRE_REQ: begin state_d = S_PRE_WAIT; wd_d = '0; end
        S_SH_REQ:  begin state_d = S_SH_WAIT;  wd_d = '0; end
        S_LD_REQ:  begin state_d = S_LD_WAIT;  wd_d = '0; end
        S_PRE_WAIT, S_SH_WAIT, S_LD_WAIT: begin
          // The expected ack is checked before the watchdog so it wins a tie.
          if (ack_i == exp_ack) begin
            if (state_q == S_PRE_WAIT) begin
              state_d = S_SH_REQ;
            end else if (state_q == S_SH_WAIT) begin
              shift_d = shift_q + CNT_WIDTH'(1);
              if (shift_q < LAST_SHIFT)  state_d = S_SH_REQ;
              else if (row_q < LAST_ROW) state_d = S_LD_REQ;
              else                       state_d = S_DONE;
            end else begin
              row_d   = row_q + CNT_WIDTH'(1);
              shift_d = '0;
              state_d = S_SH_REQ;
            end
          end else if (ack_i != 2'd0) begin
            state_d = S_ERR;
          end else if (wd_q >= WD_LIMIT) begin
            state_d = S_ERR;
          end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The command register follows the next state, so it holds while a REQ is stalled.
  always_comb begin
    cmd_d = 2'd0;
    case (state_d)
      S_PRE_REQ: cmd_d = 2'd1;
      S_SH_REQ:  cmd_d = 2'd2;
      S_LD_REQ:  cmd_d = 2'd3;
      default:   cmd_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= 2'd0;
      row_q   <= '0;
      shift_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      row_q   <= row_d;
      shift_q <= shift_d;
      wd_q    <= wd_d;
    end
  end

  assign cmd_o       = enable_i ? cmd_q : 2'd0;
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign done_o      = (state_q == S_DONE);
  assign error_o     = (state_q == S_ERR);
  assign row_idx_o   = row_q;
  assign shift_idx_o = shift_q;
  assign state_o     = state_q;

endmodule
